// File: rtl/rf_read_port_arbiter_if.sv
// Bundle of the request, read-mux and response signals around one shared
// register-file read port. The arbiter takes the slave view; whatever drives
// the requests and models the read mux takes the master view.
interface rf_read_port_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 5,
  parameter int WID     = 32
);
  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ*WIDTH-1:0] req_index_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic                     flush_i;
  logic [WIDTH-1:0]         mux_index_o;
  logic                     mux_read_en_o;
  logic [WID-1:0]           mux_data_i;
  logic                     mux_ready_i;
  logic [NUM_REQ-1:0]       resp_valid_o;
  logic [WID-1:0]           resp_data_o;
  logic                     resp_err_o;

  modport master (
    output req_valid_i, req_index_i, flush_i, mux_data_i, mux_ready_i,
    input  req_ready_o, mux_index_o, mux_read_en_o,
           resp_valid_o, resp_data_o, resp_err_o
  );

  modport slave (
    input  req_valid_i, req_index_i, flush_i, mux_data_i, mux_ready_i,
    output req_ready_o, mux_index_o, mux_read_en_o,
           resp_valid_o, resp_data_o, resp_err_o
  );
endinterface

// File: rtl/rf_read_port_arbiter.sv
// Round-robin arbiter sharing a single register-file read port among NUM_REQ
// requesters. At most one grant per cycle; the granted index goes straight to
// the read mux and the result comes back registered one cycle later, tagged
// with a one-hot response valid for the winning requester.
module rf_read_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 5,
  parameter int WID     = 32
) (
  input logic                 clk_i,
  input logic                 rst_i,
  rf_read_port_arbiter_if.slave bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      ptr_next;
  logic [PW-1:0]      win;
  logic [PW-1:0]      cand;
  logic [PW:0]        sum;
  logic               grant;
  logic [NUM_REQ-1:0] ready;
  logic [WIDTH-1:0]   idx_arr [NUM_REQ];
  logic [NUM_REQ-1:0] resp_valid;
  logic [WID-1:0]     resp_data;
  logic               resp_err;

  // Unflatten the per-requester indices so the winner can select one directly.
  for (genvar r = 0; r < NUM_REQ; r++) begin : g_idx
    assign idx_arr[r] = bus.req_index_i[r*WIDTH +: WIDTH];
  end

  // Search from rr_ptr upward with wrap; the first valid requester wins.
  // Reset and flush both suppress the grant so the port reads as idle.
  always_comb begin
    grant = 1'b0;
    win   = '0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum  = {1'b0, rr_ptr} + (PW+1)'(k);
      cand = (sum >= (PW+1)'(NUM_REQ)) ? PW'(sum - (PW+1)'(NUM_REQ)) : PW'(sum);
      if (!grant && bus.req_valid_i[cand]) begin
        grant = 1'b1;
        win   = cand;
      end
    end
    if (rst_i || bus.flush_i) begin
      grant = 1'b0;
    end
  end

  // Decode the winner into the one-hot grant and the read-mux drive.
  always_comb begin
    ready    = '0;
    ptr_next = rr_ptr;
    if (grant) begin
      ready[win] = 1'b1;
      ptr_next   = (int'(win) == NUM_REQ-1) ? '0 : win + PW'(1);
    end
  end

  assign bus.req_ready_o   = ready;
  assign bus.mux_read_en_o = grant;
  assign bus.mux_index_o   = grant ? idx_arr[win] : '0;

  // Advance priority past the winner and capture the read result; a cycle
  // without a grant clears valid/err but leaves the last data in place.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr     <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else if (grant) begin
      rr_ptr     <= ptr_next;
      resp_valid <= ready;
      resp_data  <= bus.mux_ready_i ? bus.mux_data_i : '0;
      resp_err   <= ~bus.mux_ready_i;
    end else begin
      resp_valid <= '0;
      resp_err   <= 1'b0;
    end
  end

  assign bus.resp_valid_o = resp_valid;
  assign bus.resp_data_o  = resp_data;
  assign bus.resp_err_o   = resp_err;
endmodule

// File: tb/tb_rf_read_port_arbiter.sv
// Bench for rf_read_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_rf_read_port_arbiter;
  localparam int N = 4;
  localparam int W = 5;
  localparam int D = 32;
  localparam int RF_DEPTH = 20;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  rf_read_port_arbiter_if #(.NUM_REQ(N), .WIDTH(W), .WID(D)) bus ();

  rf_read_port_arbiter #(.NUM_REQ(N), .WIDTH(W), .WID(D)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  logic [D-1:0] mem [32];
  assign bus.mux_data_i  = mem[bus.mux_index_o];
  assign bus.mux_ready_i = (int'(bus.mux_index_o) < RF_DEPTH);

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model state.
  int           m_ptr = 0;
  int           m_gnt = -1;
  logic [N-1:0] m_rv  = '0;
  logic [D-1:0] m_rd  = '0;
  logic         m_re  = 1'b0;

  // Compare process: mid-cycle, check everything against the model, then
  // advance the model to what the coming rising edge must produce.
  always @(negedge clk_i) begin
    int           w;
    int           ix;
    logic [N-1:0] er;
    if (rst_i) begin
      chk("rst_ready", bus.req_ready_o, 0);
      chk("rst_rd_en", bus.mux_read_en_o, 0);
      chk("rst_index", bus.mux_index_o, 0);
      chk("rst_rvalid", bus.resp_valid_o, 0);
      chk("rst_rdata", bus.resp_data_o, 0);
      chk("rst_rerr", bus.resp_err_o, 0);
      m_ptr = 0; m_gnt = -1; m_rv = '0; m_rd = '0; m_re = 1'b0;
    end else begin
      w = -1;
      if (!bus.flush_i) begin
        for (int k = 0; k < N; k++) begin
          if (w < 0 && bus.req_valid_i[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        end
      end
      er = '0;
      ix = 0;
      if (w >= 0) begin
        er[w] = 1'b1;
        ix = int'(bus.req_index_i[w*W +: W]);
      end
      chk("ready", bus.req_ready_o, er);
      chk("rd_en", bus.mux_read_en_o, (w >= 0));
      chk("index", bus.mux_index_o, ix);
      chk("rvalid", bus.resp_valid_o, m_rv);
      chk("rdata", bus.resp_data_o, m_rd);
      chk("rerr", bus.resp_err_o, m_re);
      m_gnt = w;
      if (w >= 0) begin
        m_ptr = (w + 1) % N;
        m_rv  = er;
        m_re  = (ix >= RF_DEPTH);
        m_rd  = (ix < RF_DEPTH) ? mem[ix] : '0;
      end else begin
        m_rv = '0;
        m_re = 1'b0;
      end
    end
  end

  task automatic tick(); @(posedge clk_i); #1; endtask
  task automatic mid();  @(negedge clk_i); #2; endtask

  logic [N-1:0] v;
  logic [W-1:0] ixs [N];
  logic         fl;

  task automatic apply();
    bus.req_valid_i = v;
    for (int r = 0; r < N; r++) bus.req_index_i[r*W +: W] = ixs[r];
    bus.flush_i = fl;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
  endtask

  logic [N-1:0] seq [5];
  logic [N-1:0] exp_rr [5];

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    mem[7] = 32'hDEADBEEF;
    mem[3] = 32'h12345678;
    v = '0; fl = 1'b0;
    for (int r = 0; r < N; r++) ixs[r] = '0;
    apply();
    exp_rr[0] = 4'b0001; exp_rr[1] = 4'b0010; exp_rr[2] = 4'b0100;
    exp_rr[3] = 4'b1000; exp_rr[4] = 4'b0001;

    tick(); tick();
    rst_i = 1'b0;
    chk("reset_rvalid", bus.resp_valid_o, 0);
    chk("reset_rdata", bus.resp_data_o, 0);
    chk("reset_ready", bus.req_ready_o, 0);

    // Single request from requester 1 with index 7.
    v = 4'b0010; ixs[1] = 5'd7; apply();
    mid();
    chk("single_ready", bus.req_ready_o, 4'b0010);
    chk("single_index", bus.mux_index_o, 7);
    tick();
    v = '0; apply();
    chk("single_rvalid", bus.resp_valid_o, 4'b0010);
    chk("single_rdata", bus.resp_data_o, 32'hDEADBEEF);
    chk("model_ptr", m_ptr, 2);
    v = 4'b1111; apply();
    mid();
    chk("after_single_ready", bus.req_ready_o, 4'b0100);
    tick();
    v = '0; apply();

    // Round-robin with all requesters held.
    do_reset();
    v = 4'b1111; for (int r = 0; r < N; r++) ixs[r] = W'(r + 1); apply();
    for (int i = 0; i < 5; i++) begin
      mid(); seq[i] = bus.req_ready_o; tick();
      chk("rr_resp", bus.resp_valid_o, exp_rr[i]);
    end
    for (int i = 0; i < 5; i++) chk("rr_grant", seq[i], exp_rr[i]);
    v = '0; apply();

    // Wrap priority: pointer at 3 with requesters 0 and 2 pending.
    do_reset();
    v = 4'b0100; ixs[2] = 5'd4; apply();
    tick();
    v = 4'b0101; ixs[0] = 5'd9; apply();
    mid(); chk("wrap_first", bus.req_ready_o, 4'b0001); tick();
    v = 4'b0100; apply();
    mid(); chk("wrap_second", bus.req_ready_o, 4'b0100); tick();
    v = '0; apply();

    // Error path: index past the populated entries.
    v = 4'b1000; ixs[3] = 5'd25; apply();
    tick();
    v = '0; apply();
    chk("err_rvalid", bus.resp_valid_o, 4'b1000);
    chk("err_flag", bus.resp_err_o, 1);
    chk("err_rdata", bus.resp_data_o, 0);

    // Flush blocks the grant and leaves priority untouched (pointer is 0).
    v = 4'b1111; fl = 1'b1; apply();
    mid();
    chk("flush_ready", bus.req_ready_o, 0);
    chk("flush_rd_en", bus.mux_read_en_o, 0);
    tick();
    chk("flush_rvalid", bus.resp_valid_o, 0);
    fl = 1'b0; apply();
    mid(); chk("flush_ptr_kept", bus.req_ready_o, 4'b0001); tick();
    v = '0; apply();

    // Asynchronous reset while a response is on the outputs.
    do_reset();
    v = 4'b0100; ixs[2] = 5'd3; apply();
    tick();
    v = '0; apply();
    chk("pre_rst_rvalid", bus.resp_valid_o, 4'b0100);
    chk("pre_rst_rdata", bus.resp_data_o, 32'h12345678);
    #2 rst_i = 1'b1;
    #1;
    chk("async_rvalid", bus.resp_valid_o, 0);
    chk("async_rdata", bus.resp_data_o, 0);
    chk("async_rerr", bus.resp_err_o, 0);
    tick(); tick();
    rst_i = 1'b0;
    v = 4'b1111; apply();
    mid(); chk("post_rst_grant", bus.req_ready_o, 4'b0001); tick();
    v = '0; apply();

    // Randomized traffic; a requester keeps its request until granted.
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < N; r++) begin
        if (m_gnt == r || !v[r]) begin
          v[r]   = ($urandom_range(0, 99) < 55);
          ixs[r] = W'($urandom_range(0, 31));
        end
      end
      fl = ($urandom_range(0, 9) == 0);
      apply();
      if (c % 700 == 350) begin
        #2 rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        v = '0;
      end else begin
        tick();
      end
    end

    v = '0; fl = 1'b0; apply();
    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
